// File: rtl/dft_crm_pkg.sv
// Shared definitions for the CRM clock divider and its ratio-update controller.
// The divider and the controller both import this package, so the scan-shift
// qualification and the state encoding stay identical in both blocks.
package dft_crm_pkg;

   // Ratio-update sequence: accept, wait for terminal count, gate, load, acknowledge.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_TC = 3'd1,
      GATE    = 3'd2,
      LOAD    = 3'd3,
      ACK     = 3'd4
   } state_t;

   // Number of bits needed for a counter that must hold values up to maxVal.
   function automatic int cntWidth(input int maxVal);
      return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
   endfunction

   // Scan shift at normal speed; at-speed test keeps the functional path alive.
   function automatic logic testSel(input logic testMode,
                                    input logic testSe,
                                    input logic testHsMode);
      return testMode & testSe & ~testHsMode;
   endfunction

endpackage

// File: rtl/dft_crm_div_cfg_ctrl_if.sv
// Ratio-change request channel between the register/CRM control side (master)
// and the ratio-update controller (slave). cfg_req is a level held until
// cfg_ack; cfg_ratio is stable while cfg_req is high.
interface dft_crm_div_cfg_ctrl_if #(
   parameter int DIV_W = 4
);

   logic             cfg_req;
   logic [DIV_W-1:0] cfg_ratio;
   logic             cfg_ack;
   logic             cfg_err;

   modport master (
      output cfg_req,
      output cfg_ratio,
      input  cfg_ack,
      input  cfg_err
   );

   modport slave (
      input  cfg_req,
      input  cfg_ratio,
      output cfg_ack,
      output cfg_err
   );

endinterface

// File: rtl/dft_crm_div_cfg_ctrl.sv
// Runtime ratio-update controller for the CRM clock divider.
// A new ratio is only applied right after the divider's terminal count, with
// the divided clock gated around the load so no runt or stretched pulse
// escapes. If the terminal count never arrives, a bounded wait forces the
// load and leaves a sticky flag behind. During scan shift the controller
// refuses or abandons updates so the divider's bypass path is left alone.
// Every output comes straight from a flop.
module dft_crm_div_cfg_ctrl
   import dft_crm_pkg::*;
#(
   parameter int DIV_W      = 4,
   parameter int DEF_RATIO  = 3,
   parameter int GATE_CYC   = 2,
   parameter int TC_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 test_mode,
   input  logic                 test_se,
   input  logic                 test_hs_mode,
   dft_crm_div_cfg_ctrl_if.slave cfg,
   input  logic                 div_tc,
   output logic [DIV_W-1:0]     div_ratio,
   output logic                 div_load,
   output logic                 div_gate_n,
   output logic                 busy,
   output logic                 tc_timeout
);

   // One down-counter serves both the terminal-count timeout and the gate
   // window, so it is sized for whichever of the two is longer.
   localparam int CNT_MAX = (TC_TIMEOUT > GATE_CYC) ? TC_TIMEOUT : GATE_CYC;
   localparam int CNT_W   = cntWidth(CNT_MAX);

   localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TC_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYC - 1);
   localparam logic [DIV_W-1:0] DEF_VAL   = DIV_W'(DEF_RATIO);

   state_t           state_q;
   logic [DIV_W-1:0] ratio_q;
   logic [DIV_W-1:0] div_ratio_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ack_lock_q;
   logic             cfg_ack_q;
   logic             cfg_err_q;
   logic             div_load_q;
   logic             div_gate_n_q;
   logic             busy_q;
   logic             tc_timeout_q;
   logic             test_sel;

   assign test_sel = testSel(test_mode, test_se, test_hs_mode);

   // Sequencer: every output is set on the edge that enters the state it
   // belongs to. Entering ACK always arms ack_lock so a request still held
   // high is not taken twice; the lock drops once cfg_req is seen low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ratio_q      <= DEF_VAL;
         div_ratio_q  <= DEF_VAL;
         cnt_q        <= '0;
         ack_lock_q   <= 1'b0;
         cfg_ack_q    <= 1'b0;
         cfg_err_q    <= 1'b0;
         div_load_q   <= 1'b0;
         div_gate_n_q <= 1'b1;
         busy_q       <= 1'b0;
         tc_timeout_q <= 1'b0;
      end else begin
         if (!cfg.cfg_req) begin
            ack_lock_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (!test_sel && cfg.cfg_req && !ack_lock_q) begin
                  ratio_q <= cfg.cfg_ratio;
                  busy_q  <= 1'b1;
                  if (cfg.cfg_ratio == '0) begin
                     state_q    <= ACK;
                     cfg_ack_q  <= 1'b1;
                     cfg_err_q  <= 1'b1;
                     ack_lock_q <= 1'b1;
                  end else if (cfg.cfg_ratio == div_ratio_q) begin
                     state_q    <= ACK;
                     cfg_ack_q  <= 1'b1;
                     ack_lock_q <= 1'b1;
                  end else begin
                     state_q <= WAIT_TC;
                     cnt_q   <= TO_LOAD;
                  end
               end
            end

            WAIT_TC: begin
               if (test_sel) begin
                  state_q      <= ACK;
                  cfg_ack_q    <= 1'b1;
                  cfg_err_q    <= 1'b1;
                  div_gate_n_q <= 1'b1;
                  ack_lock_q   <= 1'b1;
               end else if (div_tc) begin
                  state_q      <= GATE;
                  div_gate_n_q <= 1'b0;
                  cnt_q        <= GATE_LOAD;
               end else if (cnt_q == '0) begin
                  state_q      <= GATE;
                  div_gate_n_q <= 1'b0;
                  cnt_q        <= GATE_LOAD;
                  tc_timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            GATE: begin
               if (test_sel) begin
                  state_q      <= ACK;
                  cfg_ack_q    <= 1'b1;
                  cfg_err_q    <= 1'b1;
                  div_gate_n_q <= 1'b1;
                  ack_lock_q   <= 1'b1;
               end else if (cnt_q == '0) begin
                  state_q     <= LOAD;
                  div_ratio_q <= ratio_q;
                  div_load_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            LOAD: begin
               state_q      <= ACK;
               div_load_q   <= 1'b0;
               div_gate_n_q <= 1'b1;
               cfg_ack_q    <= 1'b1;
               ack_lock_q   <= 1'b1;
            end

            ACK: begin
               state_q   <= IDLE;
               cfg_ack_q <= 1'b0;
               cfg_err_q <= 1'b0;
               busy_q    <= 1'b0;
            end

            default: begin
               state_q      <= IDLE;
               cfg_ack_q    <= 1'b0;
               cfg_err_q    <= 1'b0;
               div_load_q   <= 1'b0;
               div_gate_n_q <= 1'b1;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign cfg.cfg_ack = cfg_ack_q;
   assign cfg.cfg_err = cfg_err_q;
   assign div_ratio   = div_ratio_q;
   assign div_load    = div_load_q;
   assign div_gate_n  = div_gate_n_q;
   assign busy        = busy_q;
   assign tc_timeout  = tc_timeout_q;

endmodule

// File: tb/tb_dft_crm_div_cfg_ctrl.sv
// Self-checking bench for the CRM ratio-update controller.
// Each request pushes its expected completion (error flag, ratio seen by the
// divider, number of load strobes) onto a scoreboard; a monitor pops and
// compares whenever cfg_ack appears. The main sequence adds cycle-exact
// checks on gating, load and ack timing around each scenario.
module tb_dft_crm_div_cfg_ctrl;

   localparam int DIV_W      = 4;
   localparam int DEF_RATIO  = 3;
   localparam int GATE_CYC   = 2;
   localparam int TC_TIMEOUT = 64;

   typedef struct {
      logic             err;
      logic [DIV_W-1:0] ratio;
      int               loads;
   } expect_t;

   logic             clk;
   logic             rst;
   logic             test_mode;
   logic             test_se;
   logic             test_hs_mode;
   logic             div_tc;
   logic [DIV_W-1:0] div_ratio;
   logic             div_load;
   logic             div_gate_n;
   logic             busy;
   logic             tc_timeout;

   int               testsRun;
   int               failCount;
   int               loadCount;
   int               took;
   logic             sawActivity;
   logic [DIV_W-1:0] modelRatio;
   expect_t          sb[$];

   dft_crm_div_cfg_ctrl_if #(.DIV_W(DIV_W)) cfgIf ();

   dft_crm_div_cfg_ctrl #(
      .DIV_W      (DIV_W),
      .DEF_RATIO  (DEF_RATIO),
      .GATE_CYC   (GATE_CYC),
      .TC_TIMEOUT (TC_TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .test_mode    (test_mode),
      .test_se      (test_se),
      .test_hs_mode (test_hs_mode),
      .cfg          (cfgIf),
      .div_tc       (div_tc),
      .div_ratio    (div_ratio),
      .div_load     (div_load),
      .div_gate_n   (div_gate_n),
      .busy         (busy),
      .tc_timeout   (tc_timeout)
   );

   // Free-running 10 ns source clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [DIV_W-1:0] ratio, input bit aborted);
      expect_t e;
      e.err   = 1'b0;
      e.ratio = modelRatio;
      e.loads = 0;
      if (aborted || ratio == '0) begin
         e.err = 1'b1;
      end else if (ratio != modelRatio) begin
         e.loads    = 1;
         e.ratio    = ratio;
         modelRatio = ratio;
      end
      sb.push_back(e);
      cfgIf.cfg_req   = 1'b1;
      cfgIf.cfg_ratio = ratio;
   endtask

   task automatic waitAck(input int maxCyc, output int cycles);
      cycles = 0;
      while (cfgIf.cfg_ack !== 1'b1 && cycles < maxCyc) begin
         tick();
         cycles++;
      end
      if (cfgIf.cfg_ack !== 1'b1) checkOutput("ackTimeout", 32'd0, 32'd1);
   endtask

   task automatic releaseReq();
      cfgIf.cfg_req = 1'b0;
      tick();
   endtask

   // Scoreboard side: every ack is matched against the oldest outstanding
   // expectation, and load strobes are counted between acks.
   always @(negedge clk) begin
      if (rst) begin
         loadCount = 0;
      end else begin
         if (div_load === 1'b1) loadCount++;
         if (cfgIf.cfg_err === 1'b1 && cfgIf.cfg_ack !== 1'b1)
            checkOutput("errWithoutAck", 32'd1, 32'd0);
         if (cfgIf.cfg_ack === 1'b1) begin
            if (sb.size() == 0) begin
               checkOutput("unexpectedAck", 32'd1, 32'd0);
            end else begin
               expect_t e;
               e = sb.pop_front();
               checkOutput("ackErr", cfgIf.cfg_err, e.err);
               checkOutput("ackRatio", div_ratio, e.ratio);
               checkOutput("ackLoads", loadCount, e.loads);
               checkOutput("ackGateOpen", div_gate_n, 1);
            end
            loadCount = 0;
         end
      end
   end

   // Hard stop in case the sequence stalls somewhere unexpected.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios with cycle-exact checks.
   initial begin
      testsRun        = 0;
      failCount       = 0;
      loadCount       = 0;
      modelRatio      = DIV_W'(DEF_RATIO);
      rst             = 1'b1;
      test_mode       = 1'b0;
      test_se         = 1'b0;
      test_hs_mode    = 1'b0;
      div_tc          = 1'b0;
      cfgIf.cfg_req   = 1'b0;
      cfgIf.cfg_ratio = '0;

      repeat (3) tick();
      checkOutput("rstRatio", div_ratio, DEF_RATIO);
      checkOutput("rstGate", div_gate_n, 1);
      checkOutput("rstAck", cfgIf.cfg_ack, 0);
      checkOutput("rstErr", cfgIf.cfg_err, 0);
      checkOutput("rstLoad", div_load, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstTimeout", tc_timeout, 0);
      rst = 1'b0;
      tick();

      $display("[TB] normal update to ratio 5");
      applyStimulus(4'd5, 1'b0);
      tick();
      checkOutput("waitBusy", busy, 1);
      checkOutput("waitGate", div_gate_n, 1);
      tick();
      tick();
      div_tc = 1'b1;
      tick();
      div_tc = 1'b0;
      checkOutput("gate1", div_gate_n, 0);
      checkOutput("gate1Load", div_load, 0);
      tick();
      checkOutput("gate2", div_gate_n, 0);
      checkOutput("gate2Ratio", div_ratio, DEF_RATIO);
      tick();
      checkOutput("loadStrobe", div_load, 1);
      checkOutput("loadRatio", div_ratio, 5);
      checkOutput("loadGate", div_gate_n, 0);
      tick();
      checkOutput("ackPulse", cfgIf.cfg_ack, 1);
      checkOutput("ackGate", div_gate_n, 1);
      checkOutput("ackLoadLow", div_load, 0);
      releaseReq();
      checkOutput("ackOnePulse", cfgIf.cfg_ack, 0);

      $display("[TB] same ratio fast path");
      applyStimulus(4'd5, 1'b0);
      tick();
      checkOutput("sameAck", cfgIf.cfg_ack, 1);
      checkOutput("sameErr", cfgIf.cfg_err, 0);
      checkOutput("sameGate", div_gate_n, 1);
      releaseReq();

      $display("[TB] ratio 0 rejected, request held high");
      applyStimulus(4'd0, 1'b0);
      tick();
      checkOutput("zeroAck", cfgIf.cfg_ack, 1);
      checkOutput("zeroErr", cfgIf.cfg_err, 1);
      checkOutput("zeroRatio", div_ratio, 5);
      tick();
      sawActivity = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sawActivity = sawActivity | busy | cfgIf.cfg_ack;
         tick();
      end
      checkOutput("heldReqIgnored", sawActivity, 0);
      releaseReq();

      $display("[TB] terminal count never arrives");
      applyStimulus(4'd9, 1'b0);
      repeat (TC_TIMEOUT) tick();
      checkOutput("toLastWaitGate", div_gate_n, 1);
      checkOutput("toLastWaitFlag", tc_timeout, 0);
      checkOutput("toLastWaitBusy", busy, 1);
      tick();
      checkOutput("toGate", div_gate_n, 0);
      checkOutput("toFlag", tc_timeout, 1);
      waitAck(6, took);
      checkOutput("toAckLatency", took, GATE_CYC + 1);
      releaseReq();

      $display("[TB] scan shift during gate aborts");
      applyStimulus(4'd6, 1'b1);
      tick();
      div_tc = 1'b1;
      tick();
      div_tc = 1'b0;
      checkOutput("abortGateLow", div_gate_n, 0);
      test_mode = 1'b1;
      test_se   = 1'b1;
      tick();
      checkOutput("abortAck", cfgIf.cfg_ack, 1);
      checkOutput("abortErr", cfgIf.cfg_err, 1);
      checkOutput("abortGate", div_gate_n, 1);
      checkOutput("abortRatio", div_ratio, 9);
      test_mode = 1'b0;
      test_se   = 1'b0;
      releaseReq();
      checkOutput("timeoutSticky", tc_timeout, 1);

      $display("[TB] at-speed test during gate completes");
      applyStimulus(4'd6, 1'b0);
      tick();
      div_tc = 1'b1;
      tick();
      div_tc       = 1'b0;
      test_mode    = 1'b1;
      test_se      = 1'b1;
      test_hs_mode = 1'b1;
      waitAck(6, took);
      checkOutput("hsErr", cfgIf.cfg_err, 0);
      checkOutput("hsRatio", div_ratio, 6);
      test_mode    = 1'b0;
      test_se      = 1'b0;
      test_hs_mode = 1'b0;
      releaseReq();

      $display("[TB] scan shift in idle blocks acceptance");
      test_mode = 1'b1;
      test_se   = 1'b1;
      applyStimulus(4'd2, 1'b0);
      sawActivity = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         sawActivity = sawActivity | busy | cfgIf.cfg_ack;
      end
      checkOutput("idleScanBlocked", sawActivity, 0);
      test_mode = 1'b0;
      test_se   = 1'b0;
      tick();
      checkOutput("idleScanReleased", busy, 1);
      div_tc = 1'b1;
      tick();
      div_tc = 1'b0;
      waitAck(6, took);
      checkOutput("idleScanRatio", div_ratio, 2);
      releaseReq();

      $display("[TB] scan shift during load does not abort");
      applyStimulus(4'd4, 1'b0);
      tick();
      div_tc = 1'b1;
      tick();
      div_tc = 1'b0;
      tick();
      tick();
      checkOutput("loadPhase", div_load, 1);
      test_mode = 1'b1;
      test_se   = 1'b1;
      tick();
      checkOutput("loadScanAck", cfgIf.cfg_ack, 1);
      checkOutput("loadScanErr", cfgIf.cfg_err, 0);
      checkOutput("loadScanRatio", div_ratio, 4);
      test_mode = 1'b0;
      test_se   = 1'b0;
      releaseReq();

      $display("[TB] reset in the middle of gating");
      applyStimulus(4'd11, 1'b0);
      tick();
      div_tc = 1'b1;
      tick();
      div_tc = 1'b0;
      checkOutput("preRstGate", div_gate_n, 0);
      rst           = 1'b1;
      cfgIf.cfg_req = 1'b0;
      void'(sb.pop_back());
      modelRatio = DIV_W'(DEF_RATIO);
      tick();
      checkOutput("midRstGate", div_gate_n, 1);
      checkOutput("midRstRatio", div_ratio, DEF_RATIO);
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstAck", cfgIf.cfg_ack, 0);
      checkOutput("midRstTimeout", tc_timeout, 0);
      rst = 1'b0;
      tick();
      tick();
      checkOutput("postRstNoAck", cfgIf.cfg_ack, 0);

      $display("[TB] terminal count on the timeout edge");
      applyStimulus(4'd7, 1'b0);
      repeat (TC_TIMEOUT) tick();
      div_tc = 1'b1;
      tick();
      div_tc = 1'b0;
      checkOutput("edgeTcGate", div_gate_n, 0);
      checkOutput("edgeTcNoFlag", tc_timeout, 0);
      waitAck(6, took);
      checkOutput("edgeTcRatio", div_ratio, 7);
      releaseReq();
      tick();

      checkOutput("scoreboardDrained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
